kwta_gamma: RTL and testbench
=============================

// Module: kwta_gamma
// PURPOSE
//  Clocked k-winners-take-all with deterministic tie-breaking and an internal gamma-cycle timer.
//  Detects the first spike edge on each of NUM_INPUTS lines within a gamma cycle.
//  Passes the first K edges (lowest index wins ties) as fixed-width output pulses.
//  Sits between a column's neuron outputs and the STDP/next-layer inputs.
//  Successor to kwta: adds edge-polarity mode, priority tie-break and explicit gamma framing.
// PARAMETERS
//  NUM_INPUTS         8   number of spike lines
//  K                  3   max winners per gamma cycle, 1 <= K <= NUM_INPUTS
//  GAMMA_CYCLE_WIDTH  16  clocks per gamma cycle, > PULSE_WIDTH
//  PULSE_WIDTH        8   output pulse length in clocks, >= 1
//  FALLING_EDGE       0   0: rising-edge spikes, idle-low I/O; 1: falling-edge spikes, idle-high I/O
// PORTS
//  clk            in   1                   clock
//  rst            in   1                   synchronous, active-high reset
//  input_spikes   in   NUM_INPUTS          spike lines, edge-coded per FALLING_EDGE
//  output_spikes  out  NUM_INPUTS          winner pulses, same polarity as inputs
//  win_count      out  $clog2(K+1)         winners granted so far this gamma cycle
//  gamma_pos      out  $clog2(GAMMA_CYCLE_WIDTH)  position in gamma cycle
//  gamma_start    out  1                   high when gamma_pos == 0
// BEHAVIOUR
//  Reset
//   - gamma_pos=0, win_count=0, fired mask=0, pulse counters=0.
//   - output_spikes idle: 0 when FALLING_EDGE=0, all-ones when FALLING_EDGE=1.
//   - Previous-sample register loads idle level (0 / all-ones).
//   - rst mid-pulse kills all pulses on the next clock.
//  Gamma timer
//   - gamma_pos counts 0..GAMMA_CYCLE_WIDTH-1 and wraps to 0.
//   - On the wrap edge, fired mask, win_count and all pulse counters clear.
//   - In-flight pulses truncate at the wrap.
//   - Previous-sample register does NOT clear: a line held active across the wrap does not re-fire.
//  Edge detect
//   - ev[i] = (input_spikes[i] != prev[i]) && (input_spikes[i] is the active level).
//   - prev <= input_spikes every clock.
//  Selection (one clock)
//   - cand = ev & ~fired.
//   - Grant up to K - win_count candidates, lowest index first; the rest are discarded permanently for this cycle.
//   - Every candidate, granted or not, sets its fired bit.
//   - An edge sampled on the wrap edge belongs to the new cycle: it sees cleared state and may win.
//  Output
//   - Granted line's counter loads PULSE_WIDTH on the same edge.
//   - output_spikes[i] is active while counter != 0; the counter decrements each clock.
//   - Latency: active in the clock period right after the sampling edge, for exactly PULSE_WIDTH clocks.
//  win_count
//   - Saturates at K; once K is reached, no further grants until the wrap.
//  Registers
//   - All outputs are registered; there is no combinational input-to-output path.
// TESTING
//  Test 1 (single edge)
//   - Stimulus: rise on ch0 at gamma_pos=2.
//   - Expect: output_spikes=8'h01 for 8 clocks from gamma_pos=3; win_count=1.
//  Test 2 (sequential edges)
//   - Stimulus: rises on ch3, ch7, ch6, ch2, ch0 on consecutive clocks.
//   - Expect: pulses on 3, 7, 6 only; win_count=3; ch2 and ch0 never pulse.
//  Test 3 (simultaneous edges)
//   - Stimulus: rises on ch1, ch4, ch5, ch6 on the same clock.
//   - Expect: winners 1, 4, 5; ch6 lost; a later rise on ch2 also lost.
//  Test 4 (tie for the last slot)
//   - Stimulus: ch5 rises, then ch6, then ch2 and ch4 on the same clock.
//   - Expect: ch2 wins; ch4 lost; win_count=3.
//  Test 5 (wrap)
//   - Stimulus: ch0 rises at gamma_pos=12 and is held high across the wrap.
//   - Expect: pulse truncated at gamma_pos=0, with no re-fire.
//   - Stimulus: drop ch0, re-raise it at gamma_pos=3.
//   - Expect: new 8-clock pulse; win_count=1.
//  Test 6 (falling mode, mid-pulse reset)
//   - Stimulus: FALLING_EDGE=1, inputs held all-ones, ch1 falls.
//   - Expect: output_spikes[1]=0 for 8 clocks; all other bits stay 1.
//   - Stimulus: rst asserted mid-pulse.
//   - Expect: output_spikes=all-ones on the next clock.

Source files
------------

// File: rtl/kwta_gamma.sv
// kwta_gamma: clocked k-winners-take-all over NUM_INPUTS spike lines with
// a free-running gamma-cycle timer. The first K spike edges of each gamma
// cycle (lowest index wins ties) produce a fixed-width output pulse. Each
// line may compete at most once per gamma cycle. The timer wrap clears all
// per-cycle state and truncates in-flight pulses.
//
// There is no valid/ready handshake. The block samples input_spikes on every
// rising clock edge and presents registered outputs on every clock.
module kwta_gamma #(
  parameter int NUM_INPUTS        = 8,
  parameter int K                 = 3,
  parameter int GAMMA_CYCLE_WIDTH = 16,
  parameter int PULSE_WIDTH       = 8,
  parameter int FALLING_EDGE      = 0,
  localparam int WCW = $clog2(K + 1),
  localparam int GPW = $clog2(GAMMA_CYCLE_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_INPUTS-1:0] input_spikes,
  output logic [NUM_INPUTS-1:0] output_spikes,
  output logic [WCW-1:0]        win_count,
  output logic [GPW-1:0]        gamma_pos,
  output logic                  gamma_start
);

  localparam int CW = $clog2(PULSE_WIDTH + 1);
  localparam logic [NUM_INPUTS-1:0] IDLE = (FALLING_EDGE != 0) ? '1 : '0;

  logic [NUM_INPUTS-1:0] prev;
  logic [NUM_INPUTS-1:0] fired;
  logic [CW-1:0]         cnt [NUM_INPUTS];

  logic                  wrap;
  logic [NUM_INPUTS-1:0] fired_base;
  logic [WCW-1:0]        wc_base;
  logic [NUM_INPUTS-1:0] ev;
  logic [NUM_INPUTS-1:0] cand;
  logic [NUM_INPUTS-1:0] grant;
  logic [WCW-1:0]        wc_next;
  logic [NUM_INPUTS-1:0] fired_next;
  logic [GPW-1:0]        pos_next;
  logic [CW-1:0]         cnt_next [NUM_INPUTS];
  logic [NUM_INPUTS-1:0] out_next;

  // Next-state logic. The wrap edge behaves as if per-cycle state were
  // already clear, so an edge sampled on the wrap competes in the new cycle.
  always_comb begin
    wrap       = (gamma_pos == GPW'(GAMMA_CYCLE_WIDTH - 1));
    pos_next   = wrap ? '0 : gamma_pos + GPW'(1);
    fired_base = wrap ? '0 : fired;
    wc_base    = wrap ? '0 : win_count;
    // Changed from the previous sample and now at the active level.
    ev         = (input_spikes ^ prev) & (input_spikes ^ IDLE);
    cand       = ev & ~fired_base;
    fired_next = fired_base | cand;
    grant      = '0;
    wc_next    = wc_base;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (cand[i] && (wc_next < WCW'(K))) begin
        grant[i] = 1'b1;
        wc_next  = wc_next + WCW'(1);
      end
    end
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (grant[i]) begin
        cnt_next[i] = CW'(PULSE_WIDTH);
      end else if (wrap || (cnt[i] == '0)) begin
        cnt_next[i] = '0;
      end else begin
        cnt_next[i] = cnt[i] - CW'(1);
      end
      out_next[i] = (cnt_next[i] != '0) ^ IDLE[i];
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      gamma_pos     <= '0;
      gamma_start   <= 1'b1;
      win_count     <= '0;
      fired         <= '0;
      prev          <= IDLE;
      output_spikes <= IDLE;
      for (int i = 0; i < NUM_INPUTS; i++) cnt[i] <= '0;
    end else begin
      gamma_pos     <= pos_next;
      gamma_start   <= (pos_next == '0);
      win_count     <= wc_next;
      fired         <= fired_next;
      prev          <= input_spikes;
      output_spikes <= out_next;
      for (int i = 0; i < NUM_INPUTS; i++) cnt[i] <= cnt_next[i];
    end
  end

endmodule

// File: tb/tb_kwta_gamma.sv
// Testbench for kwta_gamma. There are two instances: one in rising-edge mode
// and one in falling-edge mode. A timestamp-based reference model predicts
// every cycle's outputs. The main process pushes those predictions into
// queues, and a monitor pops them and compares them with the DUT outputs.
module tb_kwta_gamma;

  localparam int N   = 8;
  localparam int K   = 3;
  localparam int GCW = 16;
  localparam int PW  = 8;
  localparam int WCW = $clog2(K + 1);
  localparam int GPW = $clog2(GCW);
  localparam int W   = N + WCW + GPW + 1;

  logic clk = 1'b0;
  logic rst0 = 1'b1, rst1 = 1'b1;
  logic [N-1:0] in0 = '0, in1 = '1;
  logic [N-1:0] out0, out1;
  logic [WCW-1:0] wc0, wc1;
  logic [GPW-1:0] pos0, pos1;
  logic st0, st1;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] exp_q0[$];
  logic [W-1:0] exp_q1[$];

  // Model state, indexed by DUT instance.
  int           m_pos [2];
  int           m_wins[2];
  int           m_k   [2];
  bit           m_fired[2][N];
  int           m_gedge[2][N];
  logic [N-1:0] m_prev[2];

  logic [N-1:0] cur0 = '0, cur1 = '1;

  kwta_gamma #(.NUM_INPUTS(N), .K(K), .GAMMA_CYCLE_WIDTH(GCW),
               .PULSE_WIDTH(PW), .FALLING_EDGE(0)) dut0 (
    .clk(clk), .rst(rst0), .input_spikes(in0), .output_spikes(out0),
    .win_count(wc0), .gamma_pos(pos0), .gamma_start(st0));

  kwta_gamma #(.NUM_INPUTS(N), .K(K), .GAMMA_CYCLE_WIDTH(GCW),
               .PULSE_WIDTH(PW), .FALLING_EDGE(1)) dut1 (
    .clk(clk), .rst(rst1), .input_spikes(in1), .output_spikes(out1),
    .win_count(wc1), .gamma_pos(pos1), .gamma_start(st1));

  // Clock and reset
  always #5 clk = ~clk;

  // Reference model: one sampling edge for instance d with reset r and
  // input x. Pulses are tracked by the edge index at which they were granted.
  task automatic model_step(input int d, input bit r, input logic [N-1:0] x,
                            output logic [W-1:0] e);
    logic [N-1:0] idle;
    logic [N-1:0] o;
    int           np;
    idle = (d == 1) ? '1 : '0;
    if (r) begin
      m_pos[d] = 0;
      m_wins[d] = 0;
      m_prev[d] = idle;
      for (int i = 0; i < N; i++) begin
        m_fired[d][i] = 1'b0;
        m_gedge[d][i] = -1;
      end
      e = {idle, WCW'(0), GPW'(0), 1'b1};
      return;
    end
    m_k[d]++;
    if (m_pos[d] == GCW - 1) begin
      m_wins[d] = 0;
      for (int i = 0; i < N; i++) begin
        m_fired[d][i] = 1'b0;
        m_gedge[d][i] = -1;
      end
    end
    np = (m_pos[d] + 1) % GCW;
    for (int i = 0; i < N; i++) begin
      if (x[i] != idle[i] && m_prev[d][i] == idle[i] && !m_fired[d][i]) begin
        m_fired[d][i] = 1'b1;
        if (m_wins[d] < K) begin
          m_wins[d]++;
          m_gedge[d][i] = m_k[d];
        end
      end
    end
    m_prev[d] = x;
    m_pos[d] = np;
    for (int i = 0; i < N; i++) begin
      if (m_gedge[d][i] >= 0 && (m_k[d] - m_gedge[d][i]) < PW) o[i] = ~idle[i];
      else o[i] = idle[i];
    end
    e = {o, WCW'(m_wins[d]), GPW'(np), (np == 0)};
  endtask

  // Driver: apply inputs and reset on the falling edge and push predictions.
  task automatic cycle(input bit r0, input bit r1);
    logic [W-1:0] e0, e1;
    @(negedge clk);
    rst0 = r0; rst1 = r1; in0 = cur0; in1 = cur1;
    model_step(0, r0, cur0, e0);
    model_step(1, r1, cur1, e1);
    exp_q0.push_back(e0);
    exp_q1.push_back(e1);
  endtask

  // Run plain cycles until instance 0 sits at gamma position p.
  task automatic run_to(input int p);
    for (int n = 0; n < 2 * GCW && m_pos[0] != p; n++) cycle(1'b0, 1'b0);
  endtask

  // Scoreboard monitor: compare each DUT against its oldest prediction.
  initial begin
    logic [W-1:0] e, g;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q0.size() > 0) begin
        e = exp_q0.pop_front();
        g = {out0, wc0, pos0, st0};
        checks++;
        if (g !== e) begin
          errors++;
          $display("FAIL dut0_cycle t=%0t got out=%h wc=%0d pos=%0d start=%b want out=%h wc=%0d pos=%0d start=%b",
                   $time, out0, wc0, pos0, st0, e[W-1 -: N], e[GPW+WCW -: WCW], e[GPW:1], e[0]);
        end
      end
      if (exp_q1.size() > 0) begin
        e = exp_q1.pop_front();
        g = {out1, wc1, pos1, st1};
        checks++;
        if (g !== e) begin
          errors++;
          $display("FAIL dut1_cycle t=%0t got out=%h wc=%0d pos=%0d start=%b want out=%h wc=%0d pos=%0d start=%b",
                   $time, out1, wc1, pos1, st1, e[W-1 -: N], e[GPW+WCW -: WCW], e[GPW:1], e[0]);
        end
      end
    end
  end

  // Stimulus
  initial begin
    logic [N-1:0] m;
    m_k[0] = 0;
    m_k[1] = 0;
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1);

    // Test 1: single rise on ch0 at gamma_pos 2.
    run_to(2);
    cur0 = 8'h01; cycle(1'b0, 1'b0);
    cur0 = 8'h00; run_to(0);

    // Test 2: rises on 3, 7, 6, 2, 0 on consecutive clocks.
    cur0 |= 8'h08; cycle(1'b0, 1'b0);
    cur0 |= 8'h80; cycle(1'b0, 1'b0);
    cur0 |= 8'h40; cycle(1'b0, 1'b0);
    cur0 |= 8'h04; cycle(1'b0, 1'b0);
    cur0 |= 8'h01; cycle(1'b0, 1'b0);
    run_to(14);
    cur0 = 8'h00; cycle(1'b0, 1'b0);
    run_to(0);

    // Test 3: simultaneous rises on 1, 4, 5, 6, then a later rise on 2.
    cur0 = 8'h72; cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b0);
    cur0 |= 8'h04; cycle(1'b0, 1'b0);
    run_to(14);
    cur0 = 8'h00; cycle(1'b0, 1'b0);
    run_to(0);

    // Test 4: ch5, then ch6, then ch2 and ch4 tie for the last slot.
    cur0 |= 8'h20; cycle(1'b0, 1'b0);
    cur0 |= 8'h40; cycle(1'b0, 1'b0);
    cur0 |= 8'h14; cycle(1'b0, 1'b0);
    run_to(14);
    cur0 = 8'h00; cycle(1'b0, 1'b0);

    // Test 5: ch0 rises at 12 and is held across the wrap, then re-raised at 3.
    run_to(12);
    cur0 = 8'h01;
    run_to(1);
    cur0 = 8'h00; cycle(1'b0, 1'b0);
    run_to(3);
    cur0 = 8'h01; cycle(1'b0, 1'b0);
    run_to(0);
    cur0 = 8'h00; cycle(1'b0, 1'b0);

    // Test 6: falling mode, ch1 falls, then reset mid-pulse.
    cur1 = 8'hfd; cycle(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b1);
    cur1 = 8'hff; cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b0);

    // Randomized sparse toggling on both instances, with occasional resets.
    for (int n = 0; n < 600; n++) begin
      m = N'($urandom & $urandom & $urandom);
      cur0 ^= m;
      m = N'($urandom & $urandom & $urandom);
      cur1 ^= m;
      cycle($urandom_range(0, 199) == 0, $urandom_range(0, 199) == 0);
    end

    @(posedge clk);
    #2;
    checks++;
    if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
      errors++;
      $display("FAIL queue_drain got q0=%0d q1=%0d want 0 0", exp_q0.size(), exp_q1.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
